// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian byte/half/word load-store initiator with sub-word read-modify-write
// Optional build macro: LSU_MISALIGN_TRAP_EN (trap misaligned halfword/word requests instead of force-aligning)
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;
   localparam logic [1:0] SizeBad  = 2'b11;

   typedef enum logic [2:0] {
      Idle    = 3'd0,
      Read    = 3'd1,
      Capture = 3'd2,
      Write   = 3'd3,
      Resp    = 3'd4
   } stateT;

   stateT state;
   stateT stateNext;

   logic [ADDR_W-1:0] addrQ;
   logic [1:0]        sizeQ;
   logic              unsQ;
   logic              writeQ;
   logic              errQ;
   logic [DATA_W-1:0] wdataQ;
   logic [DATA_W-1:0] mergeQ;
   logic [DATA_W-1:0] rdataQ;

   logic              accept;
   logic              reqErr;
   logic [DATA_W-1:0] loadVal;
   logic [DATA_W-1:0] mergeVal;
   logic [7:0]        laneByte;
   logic [15:0]       laneHalf;

   assign accept = req_valid && (state == Idle);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((req_size == SizeHalf) && req_addr[0]) ||
                       ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
   assign reqErr = (req_size == SizeBad) || misaligned;
`else
   // Misaligned requests fall through: lane selection ignores the low address
   // bits a halfword/word cannot use, which force-aligns them.
   assign reqErr = (req_size == SizeBad);
`endif

   // Memory interface decodes from state and latched registers only, so reset
   // drops the strobes immediately.
   assign mem_addr   = {addrQ[ADDR_W-1:2], 2'b00};
   assign mem_wdata  = (sizeQ == SizeWord) ? wdataQ : mergeQ;
   assign resp_rdata = rdataQ;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= Idle;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and handshake/strobe decode.
   always_comb begin
      stateNext  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state)
         Idle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (reqErr) begin
                  stateNext = Resp;
               end else if (req_write && (req_size == SizeWord)) begin
                  stateNext = Write;
               end else begin
                  stateNext = Read;
               end
            end
         end
         Read: begin
            mem_read  = 1'b1;
            stateNext = Capture;
         end
         Capture: begin
            stateNext = writeQ ? Write : Resp;
         end
         Write: begin
            mem_write = 1'b1;
            stateNext = Resp;
         end
         Resp: begin
            resp_valid = 1'b1;
            resp_err   = errQ;
            stateNext  = Idle;
         end
         default: begin
            stateNext = Idle;
         end
      endcase
   end

   // Load lane select and extension; offset 0 is the most significant byte.
   always_comb begin
      laneByte = 8'h00;
      laneHalf = 16'h0000;
      loadVal  = '0;
      case (addrQ[1:0])
         2'd0:    laneByte = mem_rdata[31:24];
         2'd1:    laneByte = mem_rdata[23:16];
         2'd2:    laneByte = mem_rdata[15:8];
         default: laneByte = mem_rdata[7:0];
      endcase
      laneHalf = addrQ[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      case (sizeQ)
         SizeByte: loadVal = unsQ ? {24'h000000, laneByte} : {{24{laneByte[7]}}, laneByte};
         SizeHalf: loadVal = unsQ ? {16'h0000, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
         default:  loadVal = mem_rdata;
      endcase
   end

   // Sub-word store merge: replace the addressed lane(s) of the read word.
   always_comb begin
      mergeVal = mem_rdata;
      if (sizeQ == SizeByte) begin
         case (addrQ[1:0])
            2'd0:    mergeVal[31:24] = wdataQ[7:0];
            2'd1:    mergeVal[23:16] = wdataQ[7:0];
            2'd2:    mergeVal[15:8]  = wdataQ[7:0];
            default: mergeVal[7:0]   = wdataQ[7:0];
         endcase
      end else if (addrQ[1]) begin
         mergeVal[15:0] = wdataQ[15:0];
      end else begin
         mergeVal[31:16] = wdataQ[15:0];
      end
   end

   // Request latch at accept, then load result or merge word at capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addrQ  <= '0;
         sizeQ  <= 2'b00;
         unsQ   <= 1'b0;
         writeQ <= 1'b0;
         errQ   <= 1'b0;
         wdataQ <= '0;
         mergeQ <= '0;
         rdataQ <= '0;
      end else begin
         if (accept) begin
            addrQ  <= req_addr;
            sizeQ  <= req_size;
            unsQ   <= req_unsigned;
            writeQ <= req_write;
            errQ   <= reqErr;
            wdataQ <= req_wdata;
            rdataQ <= '0;
         end
         if (state == Capture) begin
            if (writeQ) begin
               mergeQ <= mergeVal;
            end else begin
               rdataQ <= loadVal;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] memw [0:63];
   logic        pokeEn;
   logic [5:0]  pokeIdx;
   logic [31:0] pokeData;
   int          wrCount = 0;
   int          rdCount = 0;
   int          bothHigh = 0;
   logic [31:0] lastWAddr = 32'h0;
   logic [31:0] lastWData = 32'h0;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_err(resp_err),
      .resp_rdata(resp_rdata),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Word-wide memory model with one-cycle read latency and a backdoor poke port.
   always @(posedge clk) begin
      if (pokeEn) memw[pokeIdx] <= pokeData;
      if (mem_write) begin
         memw[mem_addr[7:2]] <= mem_wdata;
         wrCount   <= wrCount + 1;
         lastWAddr <= mem_addr;
         lastWData <= mem_wdata;
      end
      if (mem_read) begin
         mem_rdata <= memw[mem_addr[7:2]];
         rdCount   <= rdCount + 1;
      end
      if (mem_read && mem_write) bothHigh <= bothHigh + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [5:0] idx, input logic [31:0] data);
      pokeEn = 1'b1; pokeIdx = idx; pokeData = data;
      @(negedge clk);
      pokeEn = 1'b0;
   endtask

   // Issue one request from IDLE; returns latency in cycles from the accept edge.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      @(negedge clk);
   endtask

   initial begin
      int          lat;
      int          w0;
      int          r0;
      int          n;
      int          busyBad;
      logic [31:0] rd;
      logic        er;

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pokeEn = 1'b0; pokeIdx = 6'd0; pokeData = 32'h0;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Word store then word load at address 20.
      w0 = wrCount; r0 = rdCount;
      issue(1'b1, 2'b10, 1'b0, 32'd20, 32'd50, lat, rd, er);
      chk("wst_lat", 32'(lat), 32'd2);
      chk("wst_err", 32'(er), 32'd0);
      chk("wst_rdata", rd, 32'h0);
      chk("wst_nwrites", 32'(wrCount - w0), 32'd1);
      chk("wst_nreads", 32'(rdCount - r0), 32'd0);
      chk("wst_waddr", lastWAddr, 32'd20);
      chk("wst_wdata", lastWData, 32'd50);
      issue(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, lat, rd, er);
      chk("wld_lat", 32'(lat), 32'd3);
      chk("wld_rdata", rd, 32'd50);
      chk("wld_err", 32'(er), 32'd0);

      // Byte store read-modify-write.
      poke(6'd5, 32'h11223344);
      w0 = wrCount; r0 = rdCount;
      issue(1'b1, 2'b00, 1'b0, 32'd22, 32'h000000AB, lat, rd, er);
      chk("bst_lat", 32'(lat), 32'd4);
      chk("bst_mem", memw[5], 32'h1122AB44);
      chk("bst_waddr", lastWAddr, 32'd20);
      chk("bst_nreads", 32'(rdCount - r0), 32'd1);
      chk("bst_nwrites", 32'(wrCount - w0), 32'd1);
      chk("bst_rdata", rd, 32'h0);

      // Halfword store to the low half.
      issue(1'b1, 2'b01, 1'b0, 32'd22, 32'h1234BEEF, lat, rd, er);
      chk("hst_lat", 32'(lat), 32'd4);
      chk("hst_mem", memw[5], 32'h1122BEEF);

      // Sign / zero extension.
      poke(6'd10, 32'h80FF7F01);
      issue(1'b0, 2'b00, 1'b0, 32'd40, 32'h0, lat, rd, er);
      chk("lb40_s", rd, 32'hFFFFFF80);
      issue(1'b0, 2'b00, 1'b1, 32'd40, 32'h0, lat, rd, er);
      chk("lb40_u", rd, 32'h00000080);
      issue(1'b0, 2'b00, 1'b0, 32'd41, 32'h0, lat, rd, er);
      chk("lb41_s", rd, 32'hFFFFFFFF);
      issue(1'b0, 2'b00, 1'b1, 32'd43, 32'h0, lat, rd, er);
      chk("lb43_u", rd, 32'h00000001);
      issue(1'b0, 2'b01, 1'b0, 32'd42, 32'h0, lat, rd, er);
      chk("lh42_s", rd, 32'h00007F01);
      issue(1'b0, 2'b01, 1'b0, 32'd40, 32'h0, lat, rd, er);
      chk("lh40_s", rd, 32'hFFFF80FF);
      issue(1'b0, 2'b01, 1'b1, 32'd40, 32'h0, lat, rd, er);
      chk("lh40_u", rd, 32'h000080FF);
      chk("lh40_lat", 32'(lat), 32'd3);

      // Misaligned requests.
      r0 = rdCount;
      issue(1'b0, 2'b10, 1'b0, 32'd41, 32'h0, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_w_lat", 32'(lat), 32'd1);
      chk("mis_w_err", 32'(er), 32'd1);
      chk("mis_w_rdata", rd, 32'h0);
      chk("mis_w_nreads", 32'(rdCount - r0), 32'd0);
      issue(1'b0, 2'b01, 1'b0, 32'd43, 32'h0, lat, rd, er);
      chk("mis_h_err", 32'(er), 32'd1);
`else
      chk("mis_w_lat", 32'(lat), 32'd3);
      chk("mis_w_err", 32'(er), 32'd0);
      chk("mis_w_rdata", rd, 32'h80FF7F01);
      chk("mis_w_nreads", 32'(rdCount - r0), 32'd1);
      issue(1'b0, 2'b01, 1'b0, 32'd43, 32'h0, lat, rd, er);
      chk("mis_h_rdata", rd, 32'h00007F01);
`endif

      // Illegal size errors in every build with no memory access.
      w0 = wrCount; r0 = rdCount;
      issue(1'b1, 2'b11, 1'b0, 32'd40, 32'hDEADBEEF, lat, rd, er);
      chk("ill_lat", 32'(lat), 32'd1);
      chk("ill_err", 32'(er), 32'd1);
      chk("ill_rdata", rd, 32'h0);
      chk("ill_noaccess", 32'((wrCount - w0) + (rdCount - r0)), 32'd0);
      chk("ill_mem", memw[10], 32'h80FF7F01);

      // Reset during the WRITE phase of a byte store.
      poke(6'd6, 32'hCAFEF00D);
      w0 = wrCount;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'd24; req_wdata = 32'h00000055;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstw_pre_write", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstw_mem_write", 32'(mem_write), 32'd0);
      chk("rstw_req_ready", 32'(req_ready), 32'd1);
      chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstw_mem", memw[6], 32'hCAFEF00D);
      chk("rstw_nwrites", 32'(wrCount - w0), 32'd0);

      // Back-to-back word loads with req_valid held high.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'd20;
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'd40;
      busyBad = 0; n = 0;
      while (!resp_valid && n < 10) begin
         if (req_ready) busyBad++;
         @(negedge clk);
         n++;
      end
      chk("b2b_first_lat", 32'(n + 1), 32'd3);
      chk("b2b_busy_ready", 32'(busyBad), 32'd0);
      chk("b2b_resp_ready", 32'(req_ready), 32'd0);
      chk("b2b_first_rdata", resp_rdata, 32'h1122BEEF);
      @(negedge clk);
      chk("b2b_idle_ready", 32'(req_ready), 32'd1);
      chk("b2b_idle_resp", 32'(resp_valid), 32'd0);
      n = 1;
      while (!resp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      chk("b2b_second_gap", 32'(n), 32'd4);
      chk("b2b_second_rdata", resp_rdata, 32'h80FF7F01);
      @(negedge clk);

      chk("strobe_overlap", 32'(bothHigh), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the byte-addressed, big-endian data memory. Takes CPU load/store requests of byte, halfword or word size and drives the memory's read/write strobe, address and data interface.
- The memory always transfers 4 bytes starting at the presented address, so sub-word stores are done as an aligned read-modify-write.
- Loads are returned zero- or sign-extended on a valid/ready request and response handshake.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
- ADDR_W, 32, address width of the request and memory ports.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified for sub-word sizes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal request.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address, always {addr[31:2],2'b00}.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_read is sampled.

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, latched address/data/merge registers 0.
- Strobes: mem_read, mem_write, mem_addr and mem_wdata decode from state and latched registers only. rst therefore drops mem_write/mem_read immediately, including mid-transaction. An interrupted store may leave memory untouched; it is never partially written.
- Memory contract: byte lane order is big-endian. Offset 0 maps to bits [31:24] and offset 3 to [7:0]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0]. mem_read and mem_write are never high in the same cycle.
- Alignment check at accept: halfword needs addr[0]=0, word needs addr[1:0]=00, size 11 is always illegal.
- State IDLE: req_ready=1. A handshake occurs when req_valid=1 on an edge; it latches addr, size, unsigned, write and wdata.
  - Error request -> RESP with err=1.
  - Word store -> WRITE.
  - Load or sub-word store -> READ.
  - req_valid=0 -> stay in IDLE.
- State READ: mem_read=1; next state CAPTURE.
- State CAPTURE: samples mem_rdata.
  - Load: resp_rdata <= selected lane, extended per req_unsigned; next state RESP.
  - Sub-word store: merge register <= mem_rdata with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]; next state WRITE.
- State WRITE: mem_write=1. mem_wdata = merge register (sub-word) or latched wdata (word); next state RESP.
- State RESP: resp_valid=1 for exactly one cycle, resp_err as latched; next state IDLE. req_ready=0 in every state except IDLE, so requests are never accepted during RESP.
- Latency from accept edge to resp_valid:
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- Back-to-back: the next request is accepted on the edge after RESP.
- Request inputs are ignored outside IDLE; the latched copy is used throughout the transaction.
- Address wrap: mem_addr is aligned, so the memory never accesses a crossing group.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned halfword/word requests give resp_valid with resp_err=1 after 1 cycle. No memory access is made.
- Not defined: misaligned requests are force-aligned (halfword clears addr[0], word clears addr[1:0]) and execute normally with resp_err=0. Size 11 still errors in both builds.

Test Plan:
- Word store then load: store addr 20, wdata 32'd50, then load word addr 20 -> mem_write high 1 cycle with mem_addr 20, mem_wdata 50; load resp_rdata=50 three cycles after accept.
- Byte store RMW: memory[20..23]=11 22 33 44 hex, store byte 0xAB to addr 22 -> READ then WRITE of 0x1122AB44 to addr 20; resp_valid 4 cycles after accept.
- Sign/zero extension: word 0x80FF7F01 at addr 40. Load byte addr 40 signed -> 0xFFFFFF80; unsigned -> 0x00000080. Load half addr 42 signed -> 0x00007F01.
- Misaligned word load addr 41 -> with LSU_MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, no mem_read. Without it: reads addr 40 and returns 0x80FF7F01 with resp_err=0.
- Reset mid-store: assert rst during WRITE of a sub-word store -> mem_write drops the same cycle, req_ready=1, resp_valid=0, memory unchanged.
- Back-to-back handshake: req_valid held high for two word loads -> second accepted on the edge after the first resp_valid; req_ready=0 throughout the first transaction.
